// File: rtl/bin_to_bcd4.sv
// Purpose : 14-bit binary to 4-digit BCD converter (sequential double-dabble) for a 7-segment scanner.
// Latency : 15 clk from accepted start to the done pulse; one conversion every 15 clk at best.
// Backpr. : none; start is accepted only in IDLE, and a start while busy is dropped (not queued).
//
// Build option: define BCD_SATURATE_EN to show 9999 for inputs above 9999. Without it the
// display shows bin mod 10000. ovf behaves identically in both builds.
//
// Ports:
//    clk               rising-edge system clock
//    reset             synchronous active-high reset, has priority over start
//    start             conversion request, honoured only while idle
//    bin[13:0]         unsigned value to convert, sampled only on the accepting edge
//    busy              high while the conversion is shifting
//    done              one-cycle pulse in the cycle after num0..num3/ovf are updated
//    ovf               last accepted bin was greater than 9999
//    num0..num3[3:0]   registered BCD digits (ones .. thousands), always 0..9
module bin_to_bcd4 (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [13:0] bin,
   output logic        busy,
   output logic        done,
   output logic        ovf,
   output logic [3:0]  num0,
   output logic [3:0]  num1,
   output logic [3:0]  num2,
   output logic [3:0]  num3
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic [3:0]  LAST_STEP = 4'd13;      // step counter value on the 14th shift
   localparam logic [13:0] MAX_DEC   = 14'd9999;   // largest value that fits four digits

   // ---------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------
   state_t      r_state;
   logic [13:0] r_shift;     // binary operand, consumed MSB first
   logic [19:0] r_scratch;   // five BCD digits under construction
   logic [3:0]  r_cnt;       // number of shifts already performed
   logic        r_ovf_cap;   // overflow flag of the operand being converted
   logic        r_done;
   logic        r_ovf;
   logic [3:0]  r_num0;
   logic [3:0]  r_num1;
   logic [3:0]  r_num2;
   logic [3:0]  r_num3;

   // ---------------------------------------------------------------
   // Control decode
   // ---------------------------------------------------------------
   state_t      w_state_nxt;
   logic        w_accept;    // start taken this edge
   logic        w_step;      // perform one double-dabble step this edge
   logic        w_last;      // this edge performs the final step

   // ---------------------------------------------------------------
   // Datapath wires
   // ---------------------------------------------------------------
   logic [19:0] w_adj;       // scratch after the +3 correction
   logic [33:0] w_dabble;    // {scratch, shift} after correction and left shift
   logic [15:0] w_digits;    // low four digits after the final step
   logic [15:0] w_result;    // value actually presented on num3..num0

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------
   // FSM: next state and control strobes
   // ---------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_step      = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            w_step = 1'b1;
            if (r_cnt == LAST_STEP) begin
               w_last      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Double-dabble step: any digit >= 5 would become >= 10 after the
   // doubling, so add 3 first to carry it into the next digit.
   // ---------------------------------------------------------------
   always_comb begin
      w_adj = r_scratch;
      for (int i = 0; i < 5; i++) begin
         if (r_scratch[4*i +: 4] >= 4'd5) begin
            w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
         end
      end
   end

   assign w_dabble = {w_adj, r_shift} << 1;

   // Digits 3..0 as they will stand after the final step; the
   // ten-thousands digit (w_dabble[33:30]) is intentionally dropped.
   assign w_digits = w_dabble[29:14];

`ifdef BCD_SATURATE_EN
   assign w_result = r_ovf_cap ? 16'h9999 : w_digits;
`else
   assign w_result = w_digits;
`endif

   // ---------------------------------------------------------------
   // Datapath and output registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_shift   <= '0;
         r_scratch <= '0;
         r_cnt     <= '0;
         r_ovf_cap <= 1'b0;
         r_done    <= 1'b0;
         r_ovf     <= 1'b0;
         r_num0    <= '0;
         r_num1    <= '0;
         r_num2    <= '0;
         r_num3    <= '0;
      end else begin
         r_done <= 1'b0;

         if (w_accept) begin
            r_shift   <= bin;
            r_scratch <= '0;
            r_cnt     <= '0;
            // The operand is shifted away during conversion, so the
            // overflow decision is taken while it is still intact.
            r_ovf_cap <= (bin > MAX_DEC);
         end

         if (w_step) begin
            r_scratch <= w_dabble[33:14];
            r_shift   <= w_dabble[13:0];
            r_cnt     <= r_cnt + 4'd1;
         end

         // Outputs change only here, so the display never sees a
         // half-converted value.
         if (w_last) begin
            r_num3 <= w_result[15:12];
            r_num2 <= w_result[11:8];
            r_num1 <= w_result[7:4];
            r_num0 <= w_result[3:0];
            r_ovf  <= r_ovf_cap;
            r_done <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------
   assign busy = (r_state == SHIFT);
   assign done = r_done;
   assign ovf  = r_ovf;
   assign num0 = r_num0;
   assign num1 = r_num1;
   assign num2 = r_num2;
   assign num3 = r_num3;

endmodule

// File: doc/bin_to_bcd4.md
BIN_TO_BCD4 -- requirements
Module: bin_to_bcd4

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  conversion request, sampled on the rising edge of clk.
REQ-005 bin  input  14  unsigned binary value to convert, range 0..16383.
REQ-006 busy  output  1  conversion in progress.
REQ-007 done  output  1  one-cycle pulse when the num outputs have just been updated.
REQ-008 ovf  output  1  set when the last accepted bin was greater than 9999.
REQ-009 num0, num1, num2, num3  output  4 each  registered BCD digits (num0 = ones ... num3 = thousands), directly drivable into the 4-digit 7-segment scanner's digit inputs.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-011 In IDLE with start=1 at edge k, the block SHALL capture bin into a 14-bit shift register, clear a 20-bit BCD scratch register and a 4-bit step counter, and enter SHIFT. Bin is sampled only at that edge.
REQ-012 In SHIFT, each edge SHALL add 3 to every scratch nibble that is >=5 and then shift {scratch, shift register} left by one (double-dabble). SHIFT SHALL run for exactly 14 edges, k+1 through k+14.
REQ-013 At edge k+14, the block SHALL:
- load num3..num0 from scratch digits [3:0] (after the Configuration rule);
- set ovf;
- assert done for the single cycle following edge k+14;
- return to IDLE.
REQ-014 busy SHALL be 1 exactly in the cycles following edges k through k+13, i.e. while in SHIFT. done and busy SHALL never be 1 together.
REQ-015 start while busy=1 SHALL be ignored, with no queuing. start in the done cycle SHALL be accepted (back-to-back conversions every 15 cycles).
REQ-016 num0..num3 and ovf SHALL hold their previous values throughout a conversion, so no partial digits are ever presented to the display.
REQ-017 ovf SHALL be 1 if and only if the captured bin was >9999. Scratch digit 4 (ten-thousands) SHALL never be output.
REQ-018 Every num output SHALL always hold a value in 0..9.

Reset
REQ-019 On reset=1 at an edge, the block SHALL force state=IDLE, busy=0, done=0, ovf=0 and num0..num3=0, and clear all internal registers. Reset has priority over start.
REQ-020 Reset during SHIFT SHALL abort the conversion: no done pulse and no output update.
REQ-021 An edge with reset=1 and start=1 SHALL NOT start a conversion. start on the first edge with reset=0 SHALL be accepted.

Configuration
REQ-022 Macro BCD_SATURATE_EN SHALL control overflow handling.
REQ-023 With BCD_SATURATE_EN defined, if bin>9999 the outputs SHALL be num3..num0 = 9,9,9,9.
REQ-024 Without BCD_SATURATE_EN, if bin>9999 the outputs SHALL be the low four decimal digits, i.e. bin mod 10000.
REQ-025 ovf behaviour and timing SHALL be identical in both builds.

Verification
REQ-026 reset, then start with bin=1234 at edge k -> busy for 14 cycles; done at the cycle after k+14; num3..num0 = 1,2,3,4; ovf=0.
REQ-027 Conversions of bin=0 and bin=9999 -> outputs 0,0,0,0 and 9,9,9,9 respectively, ovf=0; a second start issued in the done cycle is accepted.
REQ-028 bin=12345 -> ovf=1 and num3..num0 = 9,9,9,9 with BCD_SATURATE_EN defined, or 2,3,4,5 without it.
REQ-029 start bin=4321, then start with bin=7 at k+5 -> the second start is ignored; result 4,3,2,1; exactly one done pulse.
REQ-030 Outputs hold 1,2,3,4; start bin=5678; reset at k+7 -> no done pulse; outputs read 0,0,0,0 after the reset edge; the next start with bin=42 yields 0,0,4,2.
